// File: rtl/ahb_master_arbiter.sv
// Two-master AHB arbiter sharing one core-side bus port between fetch (m0) and load/store (m1).
// Latency: a request from the non-owner reaches the bus one cycle after it is raised; the owner's request passes through combinationally.
// Backpressure: masters are held with hready=0 unless they own the address or data phase; no state moves while slv_hready_i=0.
//
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   mK_* (K=0,1)             AHB master-side inputs (address/control/write data) and hready/hresp/hrdata outputs
//   slv_*                    AHB bus side: muxed address/control/write data out, ready/response/read data in
//   grant_o                  current address-phase owner
module ahb_master_arbiter #(
    parameter int HADDR_W     = 32,
    parameter int HDATA_W     = 32,
    parameter bit DEFAULT_MST = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    // master 0: instruction fetch
    input  logic               m0_hsel_i,
    input  logic [1:0]         m0_htrans_i,
    input  logic [HADDR_W-1:0] m0_haddr_i,
    input  logic [HDATA_W-1:0] m0_hwdata_i,
    input  logic               m0_hwrite_i,
    input  logic [2:0]         m0_hsize_i,
    input  logic [2:0]         m0_hburst_i,
    input  logic [3:0]         m0_hprot_i,
    input  logic               m0_hmastlock_i,
    input  logic               m0_priority_i,
    output logic               m0_hready_o,
    output logic               m0_hresp_o,
    output logic [HDATA_W-1:0] m0_hrdata_o,
    // master 1: load/store
    input  logic               m1_hsel_i,
    input  logic [1:0]         m1_htrans_i,
    input  logic [HADDR_W-1:0] m1_haddr_i,
    input  logic [HDATA_W-1:0] m1_hwdata_i,
    input  logic               m1_hwrite_i,
    input  logic [2:0]         m1_hsize_i,
    input  logic [2:0]         m1_hburst_i,
    input  logic [3:0]         m1_hprot_i,
    input  logic               m1_hmastlock_i,
    input  logic               m1_priority_i,
    output logic               m1_hready_o,
    output logic               m1_hresp_o,
    output logic [HDATA_W-1:0] m1_hrdata_o,
    // AHB bus side
    output logic               slv_hsel_o,
    output logic [1:0]         slv_htrans_o,
    output logic [HADDR_W-1:0] slv_haddr_o,
    output logic [HDATA_W-1:0] slv_hwdata_o,
    output logic               slv_hwrite_o,
    output logic [2:0]         slv_hsize_o,
    output logic [2:0]         slv_hburst_o,
    output logic [3:0]         slv_hprot_o,
    output logic               slv_hmastlock_o,
    input  logic               slv_hready_i,
    input  logic               slv_hresp_i,
    input  logic [HDATA_W-1:0] slv_hrdata_i,
    output logic               grant_o
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Address-phase bundle, muxed as one unit by grant.
    typedef struct packed {
        logic               hsel;
        logic [1:0]         htrans;
        logic [HADDR_W-1:0] haddr;
        logic               hwrite;
        logic [2:0]         hsize;
        logic [2:0]         hburst;
        logic [3:0]         hprot;
        logic               hmastlock;
    } hctl_t;

    hctl_t m0_ctl;
    hctl_t m1_ctl;
    hctl_t bus_ctl;

    logic grant;     // address-phase owner
    logic last_win;  // previous arbitration winner, for round robin
    logic dph_vld;   // a transfer is in its data phase
    logic dph_own;   // owner of that data phase
    logic req0;
    logic req1;
    logic lock_hold;
    logic winner;

    assign m0_ctl = {m0_hsel_i, m0_htrans_i, m0_haddr_i, m0_hwrite_i,
                     m0_hsize_i, m0_hburst_i, m0_hprot_i, m0_hmastlock_i};
    assign m1_ctl = {m1_hsel_i, m1_htrans_i, m1_haddr_i, m1_hwrite_i,
                     m1_hsize_i, m1_hburst_i, m1_hprot_i, m1_hmastlock_i};

    assign req0 = m0_hsel_i & (m0_htrans_i == HTRANS_NONSEQ);
    assign req1 = m1_hsel_i & (m1_htrans_i == HTRANS_NONSEQ);

    // Address phase: pass the granted master straight through, but never
    // present a live transfer while reset is held.
    always_comb begin
        bus_ctl = grant ? m1_ctl : m0_ctl;
        if (rst) begin
            bus_ctl.hsel   = 1'b0;
            bus_ctl.htrans = HTRANS_IDLE;
        end
    end

    assign slv_hsel_o      = bus_ctl.hsel;
    assign slv_htrans_o    = bus_ctl.htrans;
    assign slv_haddr_o     = bus_ctl.haddr;
    assign slv_hwrite_o    = bus_ctl.hwrite;
    assign slv_hsize_o     = bus_ctl.hsize;
    assign slv_hburst_o    = bus_ctl.hburst;
    assign slv_hprot_o     = bus_ctl.hprot;
    assign slv_hmastlock_o = bus_ctl.hmastlock;

    // Data phase follows the registered owner, so a handover overlaps the
    // new owner's address with the old owner's write data.
    assign slv_hwdata_o = dph_own ? m1_hwdata_i : m0_hwdata_i;
    assign m0_hresp_o   = dph_vld & ~dph_own & slv_hresp_i;
    assign m1_hresp_o   = dph_vld &  dph_own & slv_hresp_i;
    assign m0_hrdata_o  = slv_hrdata_i;
    assign m1_hrdata_o  = slv_hrdata_i;

    // A master may proceed only while it owns the address or data phase;
    // during reset both are released so they do not stall on a dead bus.
    assign m0_hready_o = rst | (slv_hready_i & (~grant | (dph_vld & ~dph_own)));
    assign m1_hready_o = rst | (slv_hready_i & ( grant | (dph_vld &  dph_own)));

    assign grant_o = grant;

    // Arbitration: a locked owner keeps the bus; otherwise a single requester
    // wins, a tie goes to higher priority, then alternates; idle parks.
    always_comb begin
        lock_hold = grant ? (m1_hmastlock_i & m1_hsel_i) : (m0_hmastlock_i & m0_hsel_i);
        winner    = grant;
        if (req0 & req1) begin
            winner = (m0_priority_i != m1_priority_i) ? m1_priority_i : ~last_win;
        end else if (req0) begin
            winner = 1'b0;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant    <= DEFAULT_MST;
            last_win <= DEFAULT_MST;
            dph_vld  <= 1'b0;
            dph_own  <= 1'b0;
        end else if (slv_hready_i) begin
            dph_vld <= grant ? req1 : req0;
            dph_own <= grant;
            if (!lock_hold) begin
                grant <= winner;
                if (req0 | req1) begin
                    last_win <= winner;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter: one record per clock cycle holds the
// stimulus and the hand-computed outputs expected in that cycle.
module tb_ahb_master_arbiter;

    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h2000_0010;
    localparam logic [31:0] W0 = 32'h0000_AAAA;
    localparam logic [31:0] W1 = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_hsel, m1_hsel;
    logic [1:0]  m0_htrans, m1_htrans;
    logic        m0_hmastlock, m1_hmastlock;
    logic        m0_priority, m1_priority;
    logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
    logic [31:0] m0_hrdata, m1_hrdata;
    logic        slv_hsel, slv_hwrite, slv_hmastlock;
    logic [1:0]  slv_htrans;
    logic [31:0] slv_haddr, slv_hwdata;
    logic [2:0]  slv_hsize, slv_hburst;
    logic [3:0]  slv_hprot;
    logic        slv_hready, slv_hresp;
    logic [31:0] slv_hrdata;
    logic        grant;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ahb_master_arbiter #(.HADDR_W(32), .HDATA_W(32), .DEFAULT_MST(1'b0)) dut (
        .clk(clk), .rst(rst),
        .m0_hsel_i(m0_hsel), .m0_htrans_i(m0_htrans), .m0_haddr_i(A0), .m0_hwdata_i(W0),
        .m0_hwrite_i(1'b0), .m0_hsize_i(3'd2), .m0_hburst_i(3'd0), .m0_hprot_i(4'h1),
        .m0_hmastlock_i(m0_hmastlock), .m0_priority_i(m0_priority),
        .m0_hready_o(m0_hready), .m0_hresp_o(m0_hresp), .m0_hrdata_o(m0_hrdata),
        .m1_hsel_i(m1_hsel), .m1_htrans_i(m1_htrans), .m1_haddr_i(A1), .m1_hwdata_i(W1),
        .m1_hwrite_i(1'b1), .m1_hsize_i(3'd2), .m1_hburst_i(3'd0), .m1_hprot_i(4'h3),
        .m1_hmastlock_i(m1_hmastlock), .m1_priority_i(m1_priority),
        .m1_hready_o(m1_hready), .m1_hresp_o(m1_hresp), .m1_hrdata_o(m1_hrdata),
        .slv_hsel_o(slv_hsel), .slv_htrans_o(slv_htrans), .slv_haddr_o(slv_haddr),
        .slv_hwdata_o(slv_hwdata), .slv_hwrite_o(slv_hwrite), .slv_hsize_o(slv_hsize),
        .slv_hburst_o(slv_hburst), .slv_hprot_o(slv_hprot), .slv_hmastlock_o(slv_hmastlock),
        .slv_hready_i(slv_hready), .slv_hresp_i(slv_hresp), .slv_hrdata_i(slv_hrdata),
        .grant_o(grant)
    );

    typedef struct {
        // stimulus
        logic rst, r0, r1, p0, p1, l0, l1, rdy, resp;
        // expected: grant, hready per master, live transfer on bus,
        // data-phase owner (selects hwdata), hresp per master
        logic e_grant, e_h0, e_h1, e_trans, e_own, e_r0, e_r1;
    } vec_t;

    function automatic vec_t V(input logic rst_, r0, r1, p0, p1, l0, l1, rdy, resp,
                               input logic eg, eh0, eh1, etr, eown, er0, er1);
        vec_t v;
        v.rst = rst_; v.r0 = r0; v.r1 = r1; v.p0 = p0; v.p1 = p1;
        v.l0 = l0; v.l1 = l1; v.rdy = rdy; v.resp = resp;
        v.e_grant = eg; v.e_h0 = eh0; v.e_h1 = eh1; v.e_trans = etr;
        v.e_own = eown; v.e_r0 = er0; v.e_r1 = er1;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after a rising edge, check at the falling
    // edge, then let the next rising edge update the arbiter.
    task automatic step(input vec_t v, input int row);
        logic [31:0] rd;
        rd = 32'hC0DE_0000 + 32'(row);
        rst          = v.rst;
        m0_hsel      = v.r0;
        m0_htrans    = v.r0 ? 2'b10 : 2'b00;
        m1_hsel      = v.r1;
        m1_htrans    = v.r1 ? 2'b10 : 2'b00;
        m0_priority  = v.p0;
        m1_priority  = v.p1;
        m0_hmastlock = v.l0;
        m1_hmastlock = v.l1;
        slv_hready   = v.rdy;
        slv_hresp    = v.resp;
        slv_hrdata   = rd;
        @(negedge clk);
        chk("grant",      row, 32'(grant),      32'(v.e_grant));
        chk("m0_hready",  row, 32'(m0_hready),  32'(v.e_h0));
        chk("m1_hready",  row, 32'(m1_hready),  32'(v.e_h1));
        chk("slv_htrans", row, 32'(slv_htrans), v.e_trans ? 32'd2 : 32'd0);
        chk("slv_hsel",   row, 32'(slv_hsel),   32'(v.e_trans));
        chk("slv_haddr",  row, slv_haddr,       v.e_grant ? A1 : A0);
        chk("slv_hwrite", row, 32'(slv_hwrite), 32'(v.e_grant));
        chk("slv_hwdata", row, slv_hwdata,      v.e_own ? W1 : W0);
        chk("m0_hresp",   row, 32'(m0_hresp),   32'(v.e_r0));
        chk("m1_hresp",   row, 32'(m1_hresp),   32'(v.e_r1));
        chk("m0_hrdata",  row, m0_hrdata,       rd);
        chk("m1_hrdata",  row, m1_hrdata,       rd);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        //                rst r0 r1 p0 p1 l0 l1 rdy rsp   g h0 h1 tr own rs0 rs1
        // reset state
        tbl.push_back(V(1,0,0,0,0,0,0,1,0, 0,1,1,0,0,0,0));
        // m1 alone from idle: held one cycle, then address, then data phase
        tbl.push_back(V(0,0,1,0,0,0,0,1,0, 0,1,0,0,0,0,0));
        tbl.push_back(V(0,0,1,0,0,0,0,1,0, 1,0,1,1,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,1,1, 1,0,1,0,1,0,1));
        tbl.push_back(V(0,0,0,0,0,0,0,1,1, 1,0,1,0,1,0,0));
        // m0 alone, leaving last_win=0
        tbl.push_back(V(0,1,0,0,0,0,0,1,0, 1,0,1,0,1,0,0));
        // both at equal priority: alternate m1, m0, m1 ...
        tbl.push_back(V(0,1,1,0,0,0,0,1,0, 0,1,0,1,1,0,0));
        tbl.push_back(V(0,1,1,0,0,0,0,1,1, 1,1,1,1,0,1,0));
        tbl.push_back(V(0,1,1,0,0,0,0,1,1, 0,1,1,1,1,0,1));
        tbl.push_back(V(0,1,1,0,0,0,0,1,0, 1,1,1,1,0,0,0));
        // m1 higher priority: keeps the bus, m0 starved
        tbl.push_back(V(0,1,1,0,1,0,0,1,0, 0,1,1,1,1,0,0));
        tbl.push_back(V(0,1,1,0,1,0,0,1,0, 1,1,1,1,0,0,0));
        tbl.push_back(V(0,1,1,0,1,0,0,1,0, 1,0,1,1,1,0,0));
        tbl.push_back(V(0,1,1,0,1,0,0,1,0, 1,0,1,1,1,0,0));
        tbl.push_back(V(0,1,1,0,1,0,0,1,0, 1,0,1,1,1,0,0));
        // m0 takes the bus, then locks it for two transfers against m1
        tbl.push_back(V(0,1,0,0,0,0,0,1,0, 1,0,1,0,1,0,0));
        tbl.push_back(V(0,1,1,0,0,1,0,1,0, 0,1,0,1,1,0,0));
        tbl.push_back(V(0,1,1,0,0,1,0,1,0, 0,1,0,1,0,0,0));
        tbl.push_back(V(0,1,1,0,0,0,0,1,0, 0,1,0,1,0,0,0));
        tbl.push_back(V(0,0,1,0,0,0,0,1,0, 1,1,1,1,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,1,0, 1,0,1,0,1,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,1,0, 1,0,1,0,1,0,0));

        rst = 1'b1;
        m0_hsel = 0; m1_hsel = 0; m0_htrans = 0; m1_htrans = 0;
        m0_hmastlock = 0; m1_hmastlock = 0; m0_priority = 0; m1_priority = 0;
        slv_hready = 1; slv_hresp = 0; slv_hrdata = 0;
        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[i]) step(tbl[i], i);

        // m1 write stalled by three wait states while m0 requests:
        // everything frozen, handover on the cycle ready returns.
        step(V(0,0,1,0,0,0,0,1,0, 1,0,1,1,1,0,0), 100);
        for (int k = 0; k < 3; k++)
            step(V(0,1,0,0,0,0,0,0,0, 1,0,0,0,1,0,0), 101 + k);
        step(V(0,1,0,0,0,0,0,1,0, 1,0,1,0,1,0,0), 104);
        step(V(0,1,0,0,0,0,0,1,0, 0,1,0,1,1,0,0), 105);

        // reset lands during an m1 data phase: bus idled, pending response dropped
        step(V(0,0,1,0,0,0,0,1,0, 0,1,0,0,0,0,0), 200);
        step(V(0,0,1,0,0,0,0,1,0, 1,0,1,1,0,0,0), 201);
        step(V(1,0,0,0,0,0,0,1,0, 1,1,1,0,1,0,0), 202);
        step(V(0,0,0,0,0,0,0,1,1, 0,1,0,0,0,0,0), 203);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
